io_mem_slave: RTL and testbench
===============================

Name: io_mem_slave

Overview:
- Parametrised byte-addressed IO memory slave. It is the successor of the fixed 256-byte, 32-bit, zero-wait, 1-cycle model used on the spike IO bus.
- Serves the same io_req/io_req_ack/io_data_ack handshake.
- Adds configurable width, depth, request wait states, read latency, region/alignment error response, and optional statistics.
- Sits behind the testbench DPI bridge as the IO target for addresses in the 0xF region.

Parameters:
- DATA_W, 32, data bus width in bits; legal values 32 or 64.
- ADDR_W, 32, address width in bits.
- DEPTH_BYTES, 256, memory size in bytes; power of two, at least DATA_W/8.
- ACK_WAIT, 0, wait cycles before io_req_ack asserts; legal range 0..7.
- RD_LAT, 1, cycles from accept edge to io_data_ack; legal range 1..4.
- REGION, 4'hF, required value of io_addr[ADDR_W-1:ADDR_W-4].

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-high.
- io_req  in  1  request valid; held until accepted.
- io_wr  in  1  1 = write, 0 = read.
- io_wen  in  DATA_W/8  byte-enable size mask; must be 2^k-1 (0001, 0011, 1111, ...). Used as access size for reads too.
- io_addr  in  ADDR_W  byte address.
- io_wdata  in  DATA_W  write data; byte i is wdata[8i+7:8i].
- io_req_ack  out  1  request accepted this cycle (combinational).
- io_data_ack  out  1  one-cycle response pulse.
- io_rdata  out  DATA_W  read data; valid only with io_data_ack on a read, otherwise 0.
- io_err  out  1  error flag; valid with io_data_ack.

Behaviour:
- Reset (rst_n=1), asynchronous:
  - io_data_ack=0, io_err=0, io_rdata=0.
  - Response pipeline valid bits cleared; wait counter=0.
  - Memory array is not cleared and contents persist across reset.
  - Assertion mid-operation drops all in-flight responses; no io_data_ack is issued for them.
- Accept:
  - io_req_ack = io_req & (wait_cnt==ACK_WAIT) & ~rst_n.
  - wait_cnt increments each cycle that io_req=1 and io_req_ack=0.
  - wait_cnt clears on accept or when io_req=0.
  - ACK_WAIT=0 gives same-cycle ack.
  - At most one accept per cycle. No backpressure from responses: the pipeline is a RD_LAT-deep shift register, so back-to-back accepts are legal.
- Error check at accept:
  - err if region mismatch, if io_wen is not of the form 2^k-1 (including 0), or if io_addr[k-1:0]!=0 where k=log2(popcount(io_wen)).
  - Errored writes do not modify memory.
  - Errored reads return io_rdata=0.
- Address mapping: off = io_addr mod DEPTH_BYTES. Byte lane i maps to mem[(off+i) mod DEPTH_BYTES], so it wraps at the top.
- Write: on the accept edge, mem[(off+i)] <= wdata byte i for each i with io_wen[i]=1.
- Read:
  - Memory is sampled on the accept edge for all DATA_W/8 lanes; lanes with io_wen[i]=0 return 0.
  - Write-then-read: a read accepted the cycle after a write sees the new data.
- Response:
  - Every accepted request (read, write, or error) produces exactly one io_data_ack.
  - The pulse appears exactly RD_LAT cycles after the accept edge, in accept order, with io_err and io_rdata aligned to it.
- Simultaneous events: a new accept and a pipeline exit in the same cycle are independent.
- Protocol violation: if io_req drops before ack, the request is discarded and wait_cnt is cleared.

Optional Feature:
- Macro: IO_MEM_STATS_EN.
- When defined, adds three outputs of 32 bits each: stat_rd, stat_wr, stat_err.
  - stat_rd increments on each accepted non-error read.
  - stat_wr increments on each accepted non-error write.
  - stat_err increments on each accepted errored request.
  - All counters reset to 0 on rst_n, saturate at 0xFFFFFFFF, and update on the accept edge.
- When undefined, these ports and all counter logic are absent; remaining behaviour is identical.

Test Plan:
- Defaults. Write addr 0xF0000010, wen 1111, wdata 0xDEADBEEF; then read the same address with wen 1111. Expected: ack same cycle, io_data_ack 1 cycle after each accept, io_rdata=0xDEADBEEF, io_err=0.
- ACK_WAIT=3, RD_LAT=4. Hold a read request. Expected: io_req_ack asserts on the 4th cycle of io_req; io_data_ack asserts exactly 4 cycles after accept.
- Wrap-around. Write addr 0xF00000FE, wen 0011, data 0x0000A55A, DEPTH_BYTES=256. Expected: mem[0xFE]=0x5A, mem[0xFF]=0xA5. Then write addr 0xF00000FC, wen 1111, data 0x11223344, and read with wen 1111 at 0xF00000FC. Expected: 0x11223344.
- Errors:
  - addr 0x10000000 read → io_err=1, io_rdata=0.
  - addr 0xF0000001 with wen 0011 → io_err=1, memory unchanged.
  - wen 0101 → io_err=1.
  - With IO_MEM_STATS_EN defined: stat_err=3 after these three.
- Back-to-back, RD_LAT=2. Five consecutive accepted reads of 0xF0000000..0xF0000010 step 4. Expected: five consecutive io_data_ack pulses, in order, with the correct data.
- Reset mid-flight, RD_LAT=3. Assert rst_n one cycle after an accept. Expected: no io_data_ack; memory content written before reset reads back unchanged afterwards.

Source files
------------

// File: rtl/io_mem_slave_if.sv
// IO memory bus: request/accept handshake plus a one-cycle response pulse.
interface io_mem_slave_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  io_req;
    logic                  io_wr;
    logic [DATA_W/8-1:0]   io_wen;
    logic [ADDR_W-1:0]     io_addr;
    logic [DATA_W-1:0]     io_wdata;
    logic                  io_req_ack;
    logic                  io_data_ack;
    logic [DATA_W-1:0]     io_rdata;
    logic                  io_err;

    modport master (
        output io_req, io_wr, io_wen, io_addr, io_wdata,
        input  io_req_ack, io_data_ack, io_rdata, io_err
    );

    modport slave (
        input  io_req, io_wr, io_wen, io_addr, io_wdata,
        output io_req_ack, io_data_ack, io_rdata, io_err
    );
endinterface

// File: rtl/io_mem_slave.sv
// Byte-addressed IO memory slave with configurable wait states, read latency
// and region/size/alignment error response.
// Optional statistics counters (stat_rd/stat_wr/stat_err) are built when the
// macro IO_MEM_STATS_EN is defined.
// Reset rst_n is asynchronous and active-high (legacy bus naming).
module io_mem_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ACK_WAIT    = 0,
    parameter int unsigned RD_LAT      = 1,
    parameter logic [3:0]  REGION      = 4'hF
) (
    input  logic           clk,
    input  logic           rst_n,
    io_mem_slave_if.slave  bus
`ifdef IO_MEM_STATS_EN
    ,
    output logic [31:0]    stat_rd,
    output logic [31:0]    stat_wr,
    output logic [31:0]    stat_err
`endif
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(NB);
    localparam int unsigned POP_W  = LANE_W + 1;
    localparam int unsigned MEM_AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W  = 3;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              accept_c;
    logic [POP_W-1:0]  pop_c;
    logic              shape_ok_c;
    logic              pow2_ok_c;
    logic              region_ok_c;
    logic              misalign_c;
    logic              err_c;
    logic [MEM_AW-1:0] off_c;
    logic [DATA_W-1:0] rd_c;
    logic [7:0]        mem_q [DEPTH_BYTES];
    resp_t             head_d;
    resp_t             pipe_q [RD_LAT];

    // Accept when the request has been held for ACK_WAIT cycles; never in reset.
    assign accept_c       = bus.io_req && (wait_cnt_q == CNT_W'(ACK_WAIT)) && !rst_n;
    assign bus.io_req_ack = accept_c;

    // Wait counter: counts held-but-unaccepted cycles, clears on accept or drop.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.io_req || accept_c) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Access size is the popcount of the enable mask.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < NB; i++) begin
            pop_c = pop_c + POP_W'(bus.io_wen[i]);
        end
    end

    // Error: wrong region, mask not a low contiguous power-of-two run, or misaligned.
    always_comb begin
        region_ok_c = (bus.io_addr[ADDR_W-1 -: 4] == REGION);
        shape_ok_c  = (bus.io_wen != '0) &&
                      ((bus.io_wen & (bus.io_wen + NB'(1))) == '0);
        pow2_ok_c   = (pop_c != '0) && ((pop_c & (pop_c - POP_W'(1))) == '0);
        misalign_c  = (bus.io_addr[LANE_W-1:0] & LANE_W'(pop_c - POP_W'(1))) != '0;
        err_c       = !region_ok_c || !shape_ok_c || !pow2_ok_c || misalign_c;
    end

    assign off_c = bus.io_addr[MEM_AW-1:0];

    // Byte write on the accept edge; lane addresses wrap at the top of memory.
    always_ff @(posedge clk) begin
        if (accept_c && bus.io_wr && !err_c) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.io_wen[i]) begin
                    mem_q[off_c + MEM_AW'(i)] <= bus.io_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read lanes sampled from memory; disabled lanes return zero.
    always_comb begin
        rd_c = '0;
        for (int i = 0; i < NB; i++) begin
            if (bus.io_wen[i]) begin
                rd_c[8*i +: 8] = mem_q[off_c + MEM_AW'(i)];
            end
        end
    end

    // New response entering the pipeline; data only for good reads.
    always_comb begin
        head_d = '0;
        if (accept_c) begin
            head_d.vld = 1'b1;
            head_d.err = err_c;
            if (!bus.io_wr && !err_c) begin
                head_d.rdata = rd_c;
            end
        end
    end

    // Fixed-latency response shift register; reset drops in-flight responses.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= head_d;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.io_data_ack = pipe_q[RD_LAT-1].vld;
    assign bus.io_err      = pipe_q[RD_LAT-1].err;
    assign bus.io_rdata    = pipe_q[RD_LAT-1].rdata;

`ifdef IO_MEM_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q, stat_err_q;

    // Saturating access counters updated on the accept edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else if (accept_c) begin
            if (err_c) begin
                if (stat_err_q != '1) stat_err_q <= stat_err_q + 32'd1;
            end else if (bus.io_wr) begin
                if (stat_wr_q != '1) stat_wr_q <= stat_wr_q + 32'd1;
            end else begin
                if (stat_rd_q != '1) stat_rd_q <= stat_rd_q + 32'd1;
            end
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_io_mem_slave.sv
// Bench for io_mem_slave: four instances with different wait/latency settings,
// checked against a byte-array reference model.
module tb_io_mem_slave;

    localparam int NDUT  = 4;
    localparam int DEPTH = 256;
    localparam int AWS [NDUT] = '{0, 3, 0, 1};
    localparam int RLS [NDUT] = '{1, 4, 2, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [NDUT-1:0] req = '0;
    logic [NDUT-1:0] wr  = '0;
    logic [3:0]      wen   [NDUT];
    logic [31:0]     addr  [NDUT];
    logic [31:0]     wdata [NDUT];

    wire  [NDUT-1:0] ack;
    wire  [NDUT-1:0] dack;
    wire  [NDUT-1:0] err;
    wire  [31:0]     rdata [NDUT];
`ifdef IO_MEM_STATS_EN
    wire  [31:0]     st_rd  [NDUT];
    wire  [31:0]     st_wr  [NDUT];
    wire  [31:0]     st_err [NDUT];
`endif

    logic [7:0] mem_m [NDUT][DEPTH];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        io_mem_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();
        assign bus.io_req   = req[g];
        assign bus.io_wr    = wr[g];
        assign bus.io_wen   = wen[g];
        assign bus.io_addr  = addr[g];
        assign bus.io_wdata = wdata[g];
        assign ack[g]   = bus.io_req_ack;
        assign dack[g]  = bus.io_data_ack;
        assign err[g]   = bus.io_err;
        assign rdata[g] = bus.io_rdata;

        io_mem_slave #(
            .DATA_W(32), .ADDR_W(32), .DEPTH_BYTES(DEPTH),
            .ACK_WAIT(AWS[g]), .RD_LAT(RLS[g]), .REGION(4'hF)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
`ifdef IO_MEM_STATS_EN
            ,
            .stat_rd  (st_rd[g]),
            .stat_wr  (st_wr[g]),
            .stat_err (st_err[g])
`endif
        );
    end

    // Reference: error rules and byte memory from the access semantics.
    function automatic void model_access(input int d, input logic w, input logic [3:0] be,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic e, output logic [31:0] rd);
        int sz;
        sz = $countones(be);
        e  = 1'b0;
        rd = '0;
        if (a[31:28] != 4'hF) e = 1'b1;
        if (!(sz == 1 || sz == 2 || sz == 4) || int'(be) != (1 << sz) - 1) e = 1'b1;
        else if ((a % 32'(sz)) != 0) e = 1'b1;
        if (!e) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    int idx;
                    idx = (int'(a % 32'(DEPTH)) + i) % DEPTH;
                    if (w) mem_m[d][idx] = wd[8*i +: 8];
                    else   rd[8*i +: 8] = mem_m[d][idx];
                end
            end
        end
    endfunction

    // Drive one request, wait (bounded) for accept and response; returns observations.
    task automatic run_txn(input int d, input logic w, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int n_wait, output int n_lat,
                           output logic got_err, output logic [31:0] got_rd);
        n_wait = 0; n_lat = 0; got_err = 1'bx; got_rd = 'x;
        req[d] = 1'b1; wr[d] = w; wen[d] = be; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        while (ack[d] !== 1'b1 && n_wait < 20) begin
            @(posedge clk); #1;
            n_wait++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
        do begin
            @(negedge clk);
            n_lat++;
            if (dack[d] === 1'b1) begin
                got_err = err[d];
                got_rd  = rdata[d];
                break;
            end
            @(posedge clk); #1;
        end while (n_lat < 12);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        req = '1;
        for (int d = 0; d < NDUT; d++) begin
            wen[d] = 4'hF; addr[d] = 32'hF000_0000; wdata[d] = '0; wr[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_req_ack dut%0d: got %b expected 0", d, ack[d]); end
            checks++;
            if ({dack[d], err[d], rdata[d]} !== 34'd0) begin
                errors++; $display("FAIL reset_outputs dut%0d: got dack=%b err=%b rdata=%h expected all 0", d, dack[d], err[d], rdata[d]);
            end
`ifdef IO_MEM_STATS_EN
            checks++;
            if ({st_rd[d], st_wr[d], st_err[d]} !== 96'd0) begin
                errors++; $display("FAIL reset_stats dut%0d: got %0d/%0d/%0d expected 0/0/0", d, st_rd[d], st_wr[d], st_err[d]);
            end
`endif
        end
        req = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        int nw, nl; logic e, me; logic [31:0] r, mr, dat;
        for (int d = 0; d < NDUT; d++) begin
            int bad;
            bad = 0;
            for (int w = 0; w < DEPTH / 4; w++) begin
                dat = $urandom;
                model_access(d, 1'b1, 4'hF, 32'hF000_0000 + 32'(4 * w), dat, me, mr);
                run_txn(d, 1'b1, 4'hF, 32'hF000_0000 + 32'(4 * w), dat, nw, nl, e, r);
                if (e !== 1'b0 || nl != RLS[d]) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL fill dut%0d: got %0d bad writes expected 0", d, bad); end
        end
    endtask

    task automatic test_defaults();
        int nw, nl; logic e, me; logic [31:0] r, mr;
        model_access(0, 1'b1, 4'hF, 32'hF000_0010, 32'hDEAD_BEEF, me, mr);
        run_txn(0, 1'b1, 4'hF, 32'hF000_0010, 32'hDEAD_BEEF, nw, nl, e, r);
        checks++;
        if (nw != 0 || nl != 1) begin errors++; $display("FAIL dflt_wr_timing: got wait=%0d lat=%0d expected 0/1", nw, nl); end
        checks++;
        if (e !== 1'b0 || r !== 32'd0) begin errors++; $display("FAIL dflt_wr_resp: got err=%b rdata=%h expected 0/0", e, r); end
        model_access(0, 1'b0, 4'hF, 32'hF000_0010, 32'd0, me, mr);
        run_txn(0, 1'b0, 4'hF, 32'hF000_0010, 32'd0, nw, nl, e, r);
        checks++;
        if (nw != 0 || nl != 1) begin errors++; $display("FAIL dflt_rd_timing: got wait=%0d lat=%0d expected 0/1", nw, nl); end
        checks++;
        if (e !== 1'b0 || r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dflt_rd_resp: got err=%b rdata=%h expected 0/deadbeef", e, r); end
    endtask

    task automatic test_ack_wait();
        int nw, nl; logic e, me; logic [31:0] r, mr;
        model_access(1, 1'b0, 4'hF, 32'hF000_0020, 32'd0, me, mr);
        run_txn(1, 1'b0, 4'hF, 32'hF000_0020, 32'd0, nw, nl, e, r);
        checks++;
        if (nw != 3) begin errors++; $display("FAIL ackwait_wait: got %0d expected 3", nw); end
        checks++;
        if (nl != 4) begin errors++; $display("FAIL ackwait_lat: got %0d expected 4", nl); end
        checks++;
        if (e !== me || r !== mr) begin errors++; $display("FAIL ackwait_data: got err=%b rdata=%h expected %b/%h", e, r, me, mr); end
    endtask

    task automatic test_wrap();
        int nw, nl; logic e, me; logic [31:0] r, mr;
        model_access(0, 1'b1, 4'h3, 32'hF000_00FE, 32'h0000_A55A, me, mr);
        run_txn(0, 1'b1, 4'h3, 32'hF000_00FE, 32'h0000_A55A, nw, nl, e, r);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL wrap_wr_err: got %b expected 0", e); end
        model_access(0, 1'b0, 4'hF, 32'hF000_00FC, 32'd0, me, mr);
        run_txn(0, 1'b0, 4'hF, 32'hF000_00FC, 32'd0, nw, nl, e, r);
        checks++;
        if (r[31:16] !== 16'hA55A || r !== mr) begin errors++; $display("FAIL wrap_rd_top: got %h expected %h (upper a55a)", r, mr); end
        model_access(0, 1'b1, 4'hF, 32'hF000_00FC, 32'h1122_3344, me, mr);
        run_txn(0, 1'b1, 4'hF, 32'hF000_00FC, 32'h1122_3344, nw, nl, e, r);
        run_txn(0, 1'b0, 4'hF, 32'hF000_00FC, 32'd0, nw, nl, e, r);
        checks++;
        if (r !== 32'h1122_3344 || e !== 1'b0) begin errors++; $display("FAIL wrap_rd_word: got err=%b rdata=%h expected 0/11223344", e, r); end
    endtask

    task automatic test_errors();
        int nw, nl; logic e, me; logic [31:0] r, mr;
        run_txn(0, 1'b0, 4'hF, 32'h1000_0000, 32'd0, nw, nl, e, r);
        checks++;
        if (e !== 1'b1 || r !== 32'd0 || nl != 1) begin errors++; $display("FAIL err_region: got err=%b rdata=%h lat=%0d expected 1/0/1", e, r, nl); end
        model_access(0, 1'b1, 4'h3, 32'hF000_0001, 32'h0000_FFFF, me, mr);
        run_txn(0, 1'b1, 4'h3, 32'hF000_0001, 32'h0000_FFFF, nw, nl, e, r);
        checks++;
        if (e !== 1'b1 || me !== 1'b1) begin errors++; $display("FAIL err_misalign: got %b expected 1", e); end
        run_txn(0, 1'b0, 4'h5, 32'hF000_0000, 32'd0, nw, nl, e, r);
        checks++;
        if (e !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL err_mask: got err=%b rdata=%h expected 1/0", e, r); end
`ifdef IO_MEM_STATS_EN
        checks++;
        if (st_err[0] !== 32'd3) begin errors++; $display("FAIL stat_err: got %0d expected 3", st_err[0]); end
`endif
        model_access(0, 1'b0, 4'hF, 32'hF000_0000, 32'd0, me, mr);
        run_txn(0, 1'b0, 4'hF, 32'hF000_0000, 32'd0, nw, nl, e, r);
        checks++;
        if (e !== 1'b0 || r !== mr) begin errors++; $display("FAIL err_mem_unchanged: got %h expected %h", r, mr); end
    endtask

    task automatic test_back_to_back();
        int d; logic me; logic [31:0] exp_rd [5];
        d = 2;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                req[d] = 1'b1; wr[d] = 1'b0; wen[d] = 4'hF;
                addr[d] = 32'hF000_0000 + 32'(4 * k);
                model_access(d, 1'b0, 4'hF, addr[d], 32'd0, me, exp_rd[k]);
            end else begin
                req[d] = 1'b0;
            end
            @(negedge clk);
            if (k < 5) begin
                checks++;
                if (ack[d] !== 1'b1) begin errors++; $display("FAIL b2b_ack cyc%0d: got %b expected 1", k, ack[d]); end
            end
            begin
                int j;
                logic exp_v;
                j = k - RLS[d];
                exp_v = (j >= 0 && j < 5);
                checks++;
                if (dack[d] !== exp_v) begin errors++; $display("FAIL b2b_dack cyc%0d: got %b expected %b", k, dack[d], exp_v); end
                if (exp_v) begin
                    checks++;
                    if (rdata[d] !== exp_rd[j] || err[d] !== 1'b0) begin
                        errors++; $display("FAIL b2b_data%0d: got err=%b rdata=%h expected 0/%h", j, err[d], rdata[d], exp_rd[j]);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int nw, nl; logic e, me, w; logic [31:0] r, mr, a, dat; logic [3:0] be;
        logic [3:0] be_tab [10];
        be_tab = '{4'h1, 4'h3, 4'hF, 4'h1, 4'h3, 4'hF, 4'h0, 4'h5, 4'h8, 4'h6};
        for (int d = 0; d < NDUT; d++) begin
            for (int t = 0; t < 40; t++) begin
                w   = 1'($urandom);
                be  = be_tab[$urandom_range(0, 9)];
                a   = {($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF, 20'($urandom), 8'($urandom)};
                dat = $urandom;
                model_access(d, w, be, a, dat, me, mr);
                run_txn(d, w, be, a, dat, nw, nl, e, r);
                checks++;
                if (nw != AWS[d] || nl != RLS[d]) begin
                    errors++; $display("FAIL rnd_timing dut%0d #%0d: got wait=%0d lat=%0d expected %0d/%0d", d, t, nw, nl, AWS[d], RLS[d]);
                end
                checks++;
                if (e !== me || r !== mr) begin
                    errors++; $display("FAIL rnd_resp dut%0d #%0d a=%h be=%h wr=%b: got err=%b rdata=%h expected %b/%h",
                                       d, t, a, be, w, e, r, me, mr);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int d, nw, nl, seen, n; logic e, me; logic [31:0] r, mr, dat;
        d = 3;
        dat = $urandom;
        model_access(d, 1'b1, 4'hF, 32'hF000_0040, dat, me, mr);
        run_txn(d, 1'b1, 4'hF, 32'hF000_0040, dat, nw, nl, e, r);
        req[d] = 1'b1; wr[d] = 1'b0; wen[d] = 4'hF; addr[d] = 32'hF000_0040;
        n = 0;
        @(negedge clk);
        while (ack[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++; @(negedge clk);
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dack !== '0) seen++;
            if (k == 3) begin @(posedge clk); #1; rst_n = 1'b0; end
        end
        checks++;
        if (seen != 0 || n >= 20) begin errors++; $display("FAIL rst_drop: got %0d acks (wait=%0d) expected 0", seen, n); end
        @(posedge clk); #1;
`ifdef IO_MEM_STATS_EN
        checks++;
        if ({st_rd[d], st_wr[d], st_err[d]} !== 96'd0) begin errors++; $display("FAIL rst_stats: got nonzero expected 0"); end
`endif
        model_access(d, 1'b0, 4'hF, 32'hF000_0040, 32'd0, me, mr);
        run_txn(d, 1'b0, 4'hF, 32'hF000_0040, 32'd0, nw, nl, e, r);
        checks++;
        if (r !== dat || e !== 1'b0 || nl != RLS[d]) begin
            errors++; $display("FAIL rst_mem_keep: got err=%b rdata=%h lat=%0d expected 0/%h/%0d", e, r, nl, dat, RLS[d]);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            wen[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        test_reset();
        test_fill();
        test_defaults();
        test_ack_wait();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
